// File: rtl/uart_pkg.sv
// Shared UART types and constants: baud-control FSM states and sync-character geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        MEASURE,
        CHECK,
        WAIT_STOP,
        LOCKED,
        ERROR
    } baud_state_t;

    localparam logic [7:0]  SYNC_CHAR       = 8'h55;
    localparam int unsigned SYNC_FALL_EDGES = 5;
    localparam int unsigned SYNC_BITS_LOG2  = 3;

endpackage

// File: rtl/uart_line_sync.sv
// Two-flop synchronizer for an async serial line plus single-cycle rise/fall pulses.
module uart_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    // Flops reset high so an idle line never produces a spurious edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            dout <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
            prev <= dout;
        end
    end

    assign rise_c = ~prev & dout;
    assign fall_c = prev & ~dout;

endmodule

// File: rtl/uart_baud_ctrl.sv
// uart_rx sequencer: fixed divisor or auto-baud measurement of the 0x55 sync character.
// Optional UART_BAUD_RELOCK_EN: a long break on the line while locked in auto mode re-enters HUNT.
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 32,
    parameter int unsigned DEFAULT_SPB  = 433,
    parameter int unsigned MIN_SAMPLES  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_in,
    input  logic                    use_fixed,
    input  logic [SAMPLE_WIDTH-1:0] fixed_samples,
    input  logic                    ab_start,
    input  logic                    ab_abort,
    output logic                    rx_enable,
    output logic [SAMPLE_WIDTH-1:0] samples_per_bit,
    output logic                    locked,
    output logic                    ab_busy,
    output logic                    ab_err
);

    localparam int unsigned SW     = SAMPLE_WIDTH;
    localparam int unsigned EDGE_W = 3;
    localparam int unsigned ROUND  = 2 ** (SYNC_BITS_LOG2 - 1);
    localparam logic [SW-1:0] CNT_MAX = '1;

    baud_state_t       state, state_nxt;
    logic [SW-1:0]     cnt, cnt_nxt;
    logic [SW-1:0]     i1, i1_nxt;
    logic [SW-1:0]     last, last_nxt;
    logic [SW-1:0]     total, total_nxt;
    logic [EDGE_W-1:0] edges, edges_nxt;
    logic              armed, armed_nxt;
    logic              mode_fixed, mode_fixed_nxt;
    logic [SW-1:0]     spb_nxt;
    logic              rx_enable_nxt, locked_nxt, ab_busy_nxt, ab_err_nxt;

    logic              rs, line_rise_c, line_fall_c;
    logic [SW-1:0]     iv_c, tol_c, diff_c, spb_calc_c;
    logic              timeout_c;
`ifdef UART_BAUD_RELOCK_EN
    logic [SW-1:0]     brk_cnt, brk_cnt_nxt, brk_lim_c;
    logic              break_c;
`endif

    uart_line_sync u_line_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (rx_in),
        .dout   (rs),
        .rise_c (line_rise_c),
        .fall_c (line_fall_c)
    );

    // Interval measurement: cnt runs from the first fall, last holds cnt at the previous fall.
    assign iv_c       = cnt - last;
    assign tol_c      = i1 >> SYNC_BITS_LOG2;
    assign diff_c     = (iv_c >= i1) ? (iv_c - i1) : (i1 - iv_c);
    assign timeout_c  = (edges >= EDGE_W'(2)) && (iv_c > (i1 + tol_c));
    assign spb_calc_c = (total + SW'(ROUND)) >> SYNC_BITS_LOG2;
`ifdef UART_BAUD_RELOCK_EN
    assign brk_lim_c  = (samples_per_bit + SW'(1)) << 4;
    assign break_c    = brk_cnt >= brk_lim_c;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            i1              <= '0;
            last            <= '0;
            total           <= '0;
            edges           <= '0;
            armed           <= 1'b0;
            mode_fixed      <= 1'b0;
            samples_per_bit <= SW'(DEFAULT_SPB);
            rx_enable       <= 1'b0;
            locked          <= 1'b0;
            ab_busy         <= 1'b0;
            ab_err          <= 1'b0;
`ifdef UART_BAUD_RELOCK_EN
            brk_cnt         <= '0;
`endif
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            i1              <= i1_nxt;
            last            <= last_nxt;
            total           <= total_nxt;
            edges           <= edges_nxt;
            armed           <= armed_nxt;
            mode_fixed      <= mode_fixed_nxt;
            samples_per_bit <= spb_nxt;
            rx_enable       <= rx_enable_nxt;
            locked          <= locked_nxt;
            ab_busy         <= ab_busy_nxt;
            ab_err          <= ab_err_nxt;
`ifdef UART_BAUD_RELOCK_EN
            brk_cnt         <= brk_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        i1_nxt         = i1;
        last_nxt       = last;
        total_nxt      = total;
        edges_nxt      = edges;
        armed_nxt      = armed;
        mode_fixed_nxt = mode_fixed;
        spb_nxt        = samples_per_bit;
`ifdef UART_BAUD_RELOCK_EN
        brk_cnt_nxt    = '0;
`endif

        if (ab_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (use_fixed) begin
                        spb_nxt        = fixed_samples;
                        mode_fixed_nxt = 1'b1;
                        state_nxt      = LOCKED;
                    end else if (ab_start) begin
                        armed_nxt = 1'b0;
                        state_nxt = HUNT;
                    end
                end
                HUNT: begin
                    if (rs) armed_nxt = 1'b1;
                    if (armed && line_fall_c) begin
                        cnt_nxt   = '0;
                        edges_nxt = EDGE_W'(1);
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    cnt_nxt = cnt + SW'(1);
                    if (cnt == CNT_MAX) begin
                        state_nxt = ERROR;
                    end else if (line_fall_c) begin
                        edges_nxt = edges + EDGE_W'(1);
                        last_nxt  = cnt;
                        if (edges == EDGE_W'(1)) begin
                            i1_nxt = cnt;
                        end else if (diff_c > tol_c) begin
                            state_nxt = ERROR;
                        end else if (edges_nxt == EDGE_W'(SYNC_FALL_EDGES)) begin
                            total_nxt = cnt;
                            state_nxt = CHECK;
                        end
                    end else if (timeout_c) begin
                        state_nxt = ERROR;
                    end
                end
                CHECK: begin
                    if (spb_calc_c < SW'(MIN_SAMPLES)) begin
                        state_nxt = ERROR;
                    end else begin
                        spb_nxt        = spb_calc_c - SW'(1);
                        mode_fixed_nxt = 1'b0;
                        state_nxt      = WAIT_STOP;
                    end
                end
                // The fifth fall leaves the line low, so the stop bit arrives as a rising edge.
                WAIT_STOP: begin
                    if (line_rise_c) state_nxt = LOCKED;
                end
                LOCKED: begin
                    if (use_fixed != mode_fixed) begin
                        state_nxt = IDLE;
                    end else if (!mode_fixed && ab_start) begin
                        armed_nxt = 1'b0;
                        state_nxt = HUNT;
`ifdef UART_BAUD_RELOCK_EN
                    end else if (!mode_fixed && break_c) begin
                        armed_nxt = 1'b0;
                        state_nxt = HUNT;
`endif
                    end
                end
                ERROR: begin
                    armed_nxt = 1'b0;
                    state_nxt = HUNT;
                end
                default: state_nxt = IDLE;
            endcase
        end

`ifdef UART_BAUD_RELOCK_EN
        if (state == LOCKED && !rs)
            brk_cnt_nxt = (brk_cnt == CNT_MAX) ? brk_cnt : brk_cnt + SW'(1);
`endif

        rx_enable_nxt = (state == LOCKED) && (state_nxt == LOCKED);
        locked_nxt    = (state == LOCKED) && (state_nxt == LOCKED);
        ab_busy_nxt   = state_nxt inside {HUNT, MEASURE, WAIT_STOP};
        ab_err_nxt    = state_nxt == ERROR;
    end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: lock/error/received-byte events are checked against a queue.
module tb_uart_baud_ctrl;

    localparam int unsigned SW = 32;
    localparam int T_BIT  = 434;
    localparam int EV_LOCK = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_BYTE = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_in;
    logic          use_fixed;
    logic [SW-1:0] fixed_samples;
    logic          ab_start;
    logic          ab_abort;
    logic          rx_enable;
    logic [SW-1:0] samples_per_bit;
    logic          locked;
    logic          ab_busy;
    logic          ab_err;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_lock = 0;
    int   n_err  = 0;
    logic locked_q = 1'b0;
    logic rxm_prev = 1'b1;

    always #5 clk = ~clk;

    uart_baud_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .rx_in           (rx_in),
        .use_fixed       (use_fixed),
        .fixed_samples   (fixed_samples),
        .ab_start        (ab_start),
        .ab_abort        (ab_abort),
        .rx_enable       (rx_enable),
        .samples_per_bit (samples_per_bit),
        .locked          (locked),
        .ab_busy         (ab_busy),
        .ab_err          (ab_err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void expect_ev(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    function automatic void sb_event(input int kind, input logic [31:0] val, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event kind %0d value %0d", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                errors++;
                $display("FAIL %s: got kind %0d value %0d expected kind %0d value %0d",
                         name, kind, val, e.kind, e.val);
            end
        end
    endfunction

    // Monitor: lock rise and error pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                locked_q = 1'b0;
            end else begin
                if (locked && !locked_q) begin
                    sb_event(EV_LOCK, samples_per_bit, "lock_spb");
                    n_lock++;
                end
                if (ab_err) begin
                    sb_event(EV_ERR, 32'(rx_enable), "ab_err_rx_enable");
                    n_err++;
                end
                locked_q = locked;
            end
        end
    end

    // Behavioural uart_rx: samples mid-bit with a period of samples_per_bit+1 clocks.
    initial begin
        logic [7:0] b;
        int p;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && rx_enable && rxm_prev && !rx_in) begin
                p = int'(samples_per_bit) + 1;
                repeat (p + p / 2 - 1) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = rx_in;
                    if (i < 7) repeat (p) @(posedge clk);
                end
                sb_event(EV_BYTE, 32'(b), "rx_byte");
            end
            rxm_prev = rx_in;
        end
    end

    task automatic send_byte(input logic [7:0] d, input int t);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = fr[i];
            repeat (t) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        ab_start = 1'b1;
        @(negedge clk);
        ab_start = 1'b0;
    endtask

    task automatic pulse_abort();
        ab_abort = 1'b1;
        @(negedge clk);
        ab_abort = 1'b0;
    endtask

    task automatic wait_count(input int which, input int target, input int max, input string name);
        int n;
        for (int i = 0; i < max; i++) begin
            n = (which == EV_LOCK) ? n_lock : n_err;
            if (n >= target) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout after %0d cycles waiting for event count %0d", name, max, target);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rx_enable"}, 32'(rx_enable), 32'd0);
        chk({tag, "_spb"},       samples_per_bit, 32'd433);
        chk({tag, "_locked"},    32'(locked), 32'd0);
        chk({tag, "_ab_busy"},   32'(ab_busy), 32'd0);
        chk({tag, "_ab_err"},    32'(ab_err), 32'd0);
    endtask

    initial begin
        int tgt;
        reset = 1'b1;
        rx_in = 1'b1;
        use_fixed = 1'b0;
        fixed_samples = '0;
        ab_start = 1'b0;
        ab_abort = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Fixed mode: divisor loaded, locked two clocks later, ab_start ignored.
        fixed_samples = 32'd100;
        expect_ev(EV_LOCK, 32'd100);
        use_fixed = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("fixed_locked_2clk", 32'(locked), 32'd1);
        chk("fixed_rx_enable", 32'(rx_enable), 32'd1);
        chk("fixed_spb", samples_per_bit, 32'd100);
        @(negedge clk);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("fixed_start_ignored_locked", 32'(locked), 32'd1);
        chk("fixed_start_ignored_busy", 32'(ab_busy), 32'd0);
        use_fixed = 1'b0;
        repeat (2) @(negedge clk);
        chk("mode_change_unlock", 32'(locked), 32'd0);
        chk("mode_change_rx_enable", 32'(rx_enable), 32'd0);

        // Auto-baud 0x55 at 434 clk/bit, then a data byte through the receiver.
        pulse_start();
        chk("auto_busy", 32'(ab_busy), 32'd1);
        tgt = n_lock + 1;
        expect_ev(EV_LOCK, 32'd433);
        send_byte(uart_pkg::SYNC_CHAR, T_BIT);
        wait_count(EV_LOCK, tgt, 4 * T_BIT, "auto_lock_wait");
        chk("auto_spb", samples_per_bit, 32'd433);
        chk("auto_busy_done", 32'(ab_busy), 32'd0);
        expect_ev(EV_BYTE, 32'hA3);
        send_byte(8'hA3, T_BIT);
        repeat (T_BIT) @(negedge clk);
        chk("auto_still_locked", 32'(locked), 32'd1);

        // Sync too fast (5 clk/bit -> spb 5 < 8): error, retry in HUNT.
        pulse_abort();
        chk("abort_unlock", 32'(locked), 32'd0);
        pulse_start();
        tgt = n_err + 1;
        expect_ev(EV_ERR, 32'd0);
        send_byte(uart_pkg::SYNC_CHAR, 5);
        wait_count(EV_ERR, tgt, 100, "fast_err_wait");
        repeat (5) @(negedge clk);
        chk("fast_err_hunt_busy", 32'(ab_busy), 32'd1);
        chk("fast_err_rx_enable", 32'(rx_enable), 32'd0);
        chk("fast_err_spb_kept", samples_per_bit, 32'd433);

        // Non-sync 0x0F: interval timeout error, then a 0x55 retry locks.
        tgt = n_err + 1;
        expect_ev(EV_ERR, 32'd0);
        send_byte(8'h0F, T_BIT);
        wait_count(EV_ERR, tgt, 3 * T_BIT, "bad_char_err_wait");
        tgt = n_lock + 1;
        expect_ev(EV_LOCK, 32'd433);
        send_byte(uart_pkg::SYNC_CHAR, T_BIT);
        wait_count(EV_LOCK, tgt, 4 * T_BIT, "retry_lock_wait");

        // Break: line low for 20 bit times while locked.
        expect_ev(EV_BYTE, 32'h00);
        rx_in = 1'b0;
        repeat (20 * T_BIT) @(negedge clk);
`ifdef UART_BAUD_RELOCK_EN
        chk("break_rx_enable", 32'(rx_enable), 32'd0);
        chk("break_busy", 32'(ab_busy), 32'd1);
        chk("break_locked", 32'(locked), 32'd0);
`else
        chk("break_locked", 32'(locked), 32'd1);
        chk("break_rx_enable", 32'(rx_enable), 32'd1);
`endif
        rx_in = 1'b1;
        repeat (5) @(negedge clk);

        // Async reset mid-MEASURE after a fixed lock at 100.
        pulse_abort();
        tgt = n_lock + 1;
        expect_ev(EV_LOCK, 32'd100);
        use_fixed = 1'b1;
        wait_count(EV_LOCK, tgt, 10, "relock_fixed_wait");
        use_fixed = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();
        rx_in = 1'b0;
        repeat (1000) @(negedge clk);
        chk("measure_busy", 32'(ab_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("async_reset");
        rx_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_locked", 32'(locked), 32'd0);
        chk("post_reset_spb", samples_per_bit, 32'd433);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
